// File: rtl/alu_collector_pkg.sv
// Shared definitions for the ALU operand collector and the ALU itself.
//   - FSM state encoding of the collector
//   - command codes (arithmetic MODE=1 / logical MODE=0)
//   - need(): which operands a command consumes, as {needB, needA}
package alu_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_GAP     = 2'd3
  } state_e;

  // Arithmetic commands (MODE = 1)
  localparam int unsigned A_ADD     = 0;
  localparam int unsigned A_SUB     = 1;
  localparam int unsigned A_ADD_CIN = 2;
  localparam int unsigned A_SUB_CIN = 3;
  localparam int unsigned A_INC_A   = 4;
  localparam int unsigned A_DEC_A   = 5;
  localparam int unsigned A_INC_B   = 6;
  localparam int unsigned A_DEC_B   = 7;
  localparam int unsigned A_CMP     = 8;
  localparam int unsigned A_MUL_INC = 9;
  localparam int unsigned A_MUL_SHL = 10;

  // Logical commands (MODE = 0)
  localparam int unsigned L_AND    = 0;
  localparam int unsigned L_NAND   = 1;
  localparam int unsigned L_OR     = 2;
  localparam int unsigned L_NOR    = 3;
  localparam int unsigned L_XOR    = 4;
  localparam int unsigned L_XNOR   = 5;
  localparam int unsigned L_NOT_A  = 6;
  localparam int unsigned L_NOT_B  = 7;
  localparam int unsigned L_SHR1_A = 8;
  localparam int unsigned L_SHL1_A = 9;
  localparam int unsigned L_SHR1_B = 10;
  localparam int unsigned L_SHL1_B = 11;
  localparam int unsigned L_ROL    = 12;
  localparam int unsigned L_ROR    = 13;

  // Returns {needB, needA}. Unknown commands need nothing, so they issue at
  // once and the ALU reports them as errors.
  function automatic logic [1:0] need(input logic mode, input int unsigned cmd);
    logic [1:0] r;
    r = 2'b00;
    if (mode) begin
      case (cmd)
        0, 1, 2, 3, 8, 9, 10: r = 2'b11;
        4, 5:                 r = 2'b01;
        6, 7:                 r = 2'b10;
        default:              r = 2'b00;
      endcase
    end else begin
      case (cmd)
        0, 1, 2, 3, 4, 5, 12, 13: r = 2'b11;
        6, 8, 9:                  r = 2'b01;
        7, 10, 11:                r = 2'b10;
        default:                  r = 2'b00;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_need_decode.sv
// Combinational operand-need lookup.
//   mode_i : 1 = arithmetic, 0 = logical
//   cmd_i  : command code
//   need_o : {needB, needA}
module alu_need_decode
  import alu_collector_pkg::*;
#(
  parameter int CMD_WIDTH = 4
) (
  input  logic                 mode_i,
  input  logic [CMD_WIDTH-1:0] cmd_i,
  output logic [1:0]           need_o
);

  assign need_o = need(mode_i, 32'(cmd_i));

endmodule

// File: rtl/alu_operand_collector.sv
// ALU operand collector: gathers OPA/OPB beats that may arrive in separate
// cycles, issues one registered command with a single-cycle CE, enforces a
// settle gap after each issue and aborts a stalled collection on timeout.
//   Upstream : IN_VALID/IN_READY handshake, IN_INP_VALID {B,A} presence,
//              IN_OPA, IN_OPB, IN_CMD, IN_MODE, IN_CIN
//   ALU side : OPA, OPB, CMD, MODE, CIN, INP_VALID, CE (all registered)
//   Status   : TO_ERR (one-cycle abort pulse), BUSY (state != IDLE)
module alu_operand_collector
  import alu_collector_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CMD_WIDTH = 4,
  parameter int TIMEOUT   = 16,
  parameter int ISSUE_GAP = 2,
  parameter int MUL_GAP   = 3
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [1:0]           IN_INP_VALID,
  input  logic [WIDTH-1:0]     IN_OPA,
  input  logic [WIDTH-1:0]     IN_OPB,
  input  logic [CMD_WIDTH-1:0] IN_CMD,
  input  logic                 IN_MODE,
  input  logic                 IN_CIN,
  output logic [WIDTH-1:0]     OPA,
  output logic [WIDTH-1:0]     OPB,
  output logic [CMD_WIDTH-1:0] CMD,
  output logic                 MODE,
  output logic                 CIN,
  output logic [1:0]           INP_VALID,
  output logic                 CE,
  output logic                 TO_ERR,
  output logic                 BUSY
);

  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int MAXGAP = (MUL_GAP > ISSUE_GAP) ? MUL_GAP : ISSUE_GAP;
  localparam int GW     = $clog2(MAXGAP + 1);

  state_e                state_q, state_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic                  mode_q, mode_d;
  logic                  cin_q, cin_d;
  logic [WIDTH-1:0]      opa_q, opa_d;
  logic [WIDTH-1:0]      opb_q, opb_d;
  logic [1:0]            have_q, have_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [GW-1:0]         gcnt_q, gcnt_d;
  logic                  abort_d;

  // Registered ALU-facing and status outputs
  logic [WIDTH-1:0]      opa_out_q, opb_out_q;
  logic [CMD_WIDTH-1:0]  cmd_out_q;
  logic                  mode_out_q, cin_out_q, ce_q, to_err_q, busy_q, ready_q;
  logic [1:0]            inp_valid_q;

  logic                  hs;
  logic                  is_mul;
  logic [CMD_WIDTH-1:0]  dec_cmd;
  logic                  dec_mode;
  logic [1:0]            need_w;

  assign hs = IN_VALID & ready_q;

  // In IDLE the command being accepted is on the input; afterwards it is the
  // latched one. Selecting here avoids decoding from the next-state logic.
  assign dec_cmd  = (state_q == ST_IDLE) ? IN_CMD  : cmd_q;
  assign dec_mode = (state_q == ST_IDLE) ? IN_MODE : mode_q;

  alu_need_decode #(.CMD_WIDTH(CMD_WIDTH)) u_need (
    .mode_i (dec_mode),
    .cmd_i  (dec_cmd),
    .need_o (need_w)
  );

  assign is_mul = mode_q && ((cmd_q == CMD_WIDTH'(A_MUL_INC)) ||
                             (cmd_q == CMD_WIDTH'(A_MUL_SHL)));

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    have_d  = have_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          cmd_d  = IN_CMD;
          mode_d = IN_MODE;
          cin_d  = IN_CIN;
          if (IN_INP_VALID[0]) opa_d = IN_OPA;
          if (IN_INP_VALID[1]) opb_d = IN_OPB;
          have_d = IN_INP_VALID;
          tcnt_d = '0;
          state_d = ((have_d & need_w) == need_w) ? ST_ISSUE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (hs) begin
          if (IN_INP_VALID[0]) opa_d = IN_OPA;
          if (IN_INP_VALID[1]) opb_d = IN_OPB;
          have_d = have_q | IN_INP_VALID;
        end
        tcnt_d = tcnt_q + TW'(1);
        // Completion wins over a timeout landing in the same cycle.
        if ((have_d & need_w) == need_w) begin
          state_d = ST_ISSUE;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
          have_d  = 2'b00;
          tcnt_d  = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_GAP;
        have_d  = 2'b00;
        gcnt_d  = is_mul ? GW'(MUL_GAP - 1) : GW'(ISSUE_GAP - 1);
      end
      ST_GAP: begin
        if (gcnt_q == '0) state_d = ST_IDLE;
        else              gcnt_d  = gcnt_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      have_q      <= 2'b00;
      tcnt_q      <= '0;
      gcnt_q      <= '0;
      opa_out_q   <= '0;
      opb_out_q   <= '0;
      cmd_out_q   <= '0;
      mode_out_q  <= 1'b0;
      cin_out_q   <= 1'b0;
      inp_valid_q <= 2'b00;
      ce_q        <= 1'b0;
      to_err_q    <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      mode_q   <= mode_d;
      cin_q    <= cin_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      have_q   <= have_d;
      tcnt_q   <= tcnt_d;
      gcnt_q   <= gcnt_d;
      // Outputs are loaded from next-state so CE is high exactly while in ISSUE.
      ce_q     <= (state_d == ST_ISSUE);
      to_err_q <= abort_d;
      busy_q   <= (state_d != ST_IDLE);
      ready_q  <= (state_d == ST_IDLE) || (state_d == ST_COLLECT);
      if (state_d == ST_ISSUE) begin
        opa_out_q   <= need_w[0] ? opa_d : '0;
        opb_out_q   <= need_w[1] ? opb_d : '0;
        cmd_out_q   <= cmd_d;
        mode_out_q  <= mode_d;
        cin_out_q   <= cin_d;
        inp_valid_q <= need_w;
      end
    end
  end

  assign IN_READY  = ready_q;
  assign OPA       = opa_out_q;
  assign OPB       = opb_out_q;
  assign CMD       = cmd_out_q;
  assign MODE      = mode_out_q;
  assign CIN       = cin_out_q;
  assign INP_VALID = inp_valid_q;
  assign CE        = ce_q;
  assign TO_ERR    = to_err_q;
  assign BUSY      = busy_q;

endmodule

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Upstream staging stage for the ALU. Receives command/operand beats in which OPA and OPB may arrive in different cycles.
- Gathers exactly the operands the command needs, then issues one complete, registered command to the ALU with a one-cycle CE pulse.
- Enforces a minimum spacing between issues so the ALU output settles before the next issue.
- Aborts an incomplete collection after a timeout and flags it.

Parameters:
- WIDTH, 4, operand width.
- CMD_WIDTH, 4, command width.
- TIMEOUT, 16, maximum cycles spent in COLLECT before abort.
- ISSUE_GAP, 2, idle cycles after a normal issue.
- MUL_GAP, 3, idle cycles after an arithmetic multiply issue (MODE=1, CMD 9 or 10).

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  upstream beat valid.
- IN_READY  out  1  collector accepts a beat this cycle.
- IN_INP_VALID  in  2  bit1 = IN_OPB present, bit0 = IN_OPA present.
- IN_OPA  in  WIDTH  operand A.
- IN_OPB  in  WIDTH  operand B.
- IN_CMD  in  CMD_WIDTH  command.
- IN_MODE  in  1  1 = arithmetic, 0 = logical.
- IN_CIN  in  1  carry in.
- OPA  out  WIDTH  to ALU.
- OPB  out  WIDTH  to ALU.
- CMD  out  CMD_WIDTH  to ALU.
- MODE  out  1  to ALU.
- CIN  out  1  to ALU.
- INP_VALID  out  2  to ALU.
- CE  out  1  one-cycle issue strobe to ALU.
- TO_ERR  out  1  one-cycle pulse on timeout abort.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset: all outputs registered. RST_N low clears everything asynchronously:
  - OPA, OPB, CMD, MODE, CIN, INP_VALID, CE, TO_ERR = 0; BUSY = 0.
  - IN_READY = 0 while RST_N is low and 1 from the first cycle after release.
  - state = IDLE, counters = 0.
  - Reset in any state discards collected data; no CE is produced.
- Need function need(MODE, CMD) returns 2 bits {needB, needA}:
  - MODE=1: CMD 0-3 and 8-10 -> 11; CMD 4,5 -> 01; CMD 6,7 -> 10.
  - MODE=0: CMD 0-5, 12, 13 -> 11; CMD 6, 8, 9 -> 01; CMD 7, 10, 11 -> 10.
  - All other commands -> 00, issued immediately; the ALU flags ERR for them.
- A handshake occurs on IN_VALID & IN_READY. IN_READY = 1 only in IDLE and COLLECT.
- IDLE:
  - On handshake, latch CMD, MODE and CIN.
  - Latch each operand whose IN_INP_VALID bit is set; set the have[1:0] bits for them.
  - If (have & need) == need: go to ISSUE.
  - Otherwise go to COLLECT with tcnt = 0.
- COLLECT:
  - Beat CMD, MODE and CIN are ignored; only operand fill applies.
  - A second copy of an operand already held overwrites it.
  - tcnt increments every cycle.
  - Fill completes the need -> ISSUE. Completion takes priority over timeout in the same cycle.
  - tcnt == TIMEOUT-1 without completion -> TO_ERR = 1 for one cycle, have cleared, back to IDLE.
- ISSUE (1 cycle):
  - CE = 1; INP_VALID = need.
  - OPA/OPB = latched values; an operand that is not needed is driven to 0.
  - Next state is GAP with gcnt loaded to MUL_GAP-1 (MODE=1 and CMD 9/10) or ISSUE_GAP-1.
- GAP:
  - CE = 0; ALU-facing data outputs hold their last values.
  - gcnt decrements; at 0 go to IDLE.
- Latency: beat in IDLE with both operands at edge N -> CE high during cycle N+1.
- Throughput: one issue per 1 + ISSUE_GAP + 1 cycles, minimum.
- Beats presented while IN_READY = 0 are not consumed; upstream holds them.

Decomposition:
- Package alu_collector_pkg:
  - state encoding IDLE=2'd0, COLLECT=2'd1, ISSUE=2'd2, GAP=2'd3;
  - CMD code constants shared with the ALU;
  - need() function.
- One sub-module, alu_need_decode: combinational need() lookup, reused by the ALU's own INP_VALID checker.
- Counters and FSM stay in the top module.

Test Plan:
- MODE=1, CMD=0, IN_INP_VALID=11, OPA=4'h3, OPB=4'h5 in IDLE -> next cycle CE=1, INP_VALID=11, OPA=3, OPB=5; IN_READY low for 3 cycles.
- MODE=1, CMD=1, beat 01 OPA=4'h9, then 6 cycles later beat 10 OPB=4'h2 -> CE one cycle after the second beat with OPA=9, OPB=2, TO_ERR never set.
- MODE=0, CMD=0, beat 01 only, no further beats -> TO_ERR pulses once 16 cycles after the handshake cycle, BUSY drops, no CE.
- MODE=1, CMD=9, both operands -> CE pulse, then IN_READY low for exactly 3 GAP cycles, next beat accepted in the following cycle.
- MODE=0, CMD=7, beat 10 OPB=4'hA -> immediate issue with INP_VALID=10, OPA=0.
- RST_N pulled low during COLLECT (after OPA received) -> outputs 0 immediately; after release a full beat issues normally with no stale OPA.
